// File: rtl/truth_table_sweeper_if.sv
// Handshake and result bundle between the sweeper and its harness/gate.
// The slave modport is the sweeper's view; the master modport is the harness view.
interface truth_table_sweeper_if;
    logic        start;
    logic        abort;
    logic [3:0]  gate_in;
    logic        gate_out;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] tt;
    logic [4:0]  mismatch_count;
    logic [3:0]  first_fail;
    logic        fail_valid;

    modport slave (
        input  start, abort, gate_out,
        output gate_in, busy, done, pass, tt, mismatch_count, first_fail, fail_valid
    );

    modport master (
        output start, abort, gate_out,
        input  gate_in, busy, done, pass, tt, mismatch_count, first_fail, fail_valid
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Steps a 4-input gate through all 16 input vectors, samples its output after a settle
// delay per vector and compares the measured truth table against EXPECTED.
module truth_table_sweeper #(
    parameter logic [15:0] EXPECTED = 16'h429B,
    parameter int unsigned SETTLE   = 2
) (
    input logic                  clk,
    input logic                  rst,
    truth_table_sweeper_if.slave io_sweep
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;
    localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

    logic        r_state,    w_state;
    logic [3:0]  r_idx,      w_idx;
    logic [7:0]  r_cnt,      w_cnt;
    logic [3:0]  r_gate_in,  w_gate_in;
    logic        r_busy,     w_busy;
    logic        r_done,     w_done;
    logic        r_pass,     w_pass;
    logic [15:0] r_tt,       w_tt;
    logic [4:0]  r_mismatch, w_mismatch;
    logic [3:0]  r_first,    w_first;
    logic        r_fvalid,   w_fvalid;
    logic        w_miss;

    assign w_miss = io_sweep.gate_out ^ EXPECTED[r_idx];

    always_comb begin
        w_state    = r_state;
        w_idx      = r_idx;
        w_cnt      = r_cnt;
        w_gate_in  = r_gate_in;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_pass     = r_pass;
        w_tt       = r_tt;
        w_mismatch = r_mismatch;
        w_first    = r_first;
        w_fvalid   = r_fvalid;
        case (r_state)
            ST_IDLE: begin
                if (io_sweep.start) begin
                    w_state    = ST_RUN;
                    w_idx      = 4'd0;
                    w_gate_in  = 4'd0;
                    w_cnt      = SETTLE_CNT;
                    w_busy     = 1'b1;
                    w_pass     = 1'b0;
                    w_tt       = 16'h0000;
                    w_mismatch = 5'd0;
                    w_first    = 4'd0;
                    w_fvalid   = 1'b0;
                end
            end
            ST_RUN: begin
                if (io_sweep.abort) begin
                    // Partial results stay visible for debug; no done pulse.
                    w_state   = ST_IDLE;
                    w_busy    = 1'b0;
                    w_gate_in = 4'd0;
                end else if (r_cnt != 8'd0) begin
                    w_cnt = r_cnt - 8'd1;
                end else begin
                    w_tt[r_idx] = io_sweep.gate_out;
                    if (w_miss) begin
                        if (r_mismatch != 5'd16) begin
                            w_mismatch = r_mismatch + 5'd1;
                        end
                        if (!r_fvalid) begin
                            w_first  = r_idx;
                            w_fvalid = 1'b1;
                        end
                    end
                    if (r_idx != 4'd15) begin
                        w_idx     = r_idx + 4'd1;
                        w_gate_in = r_idx + 4'd1;
                        w_cnt     = SETTLE_CNT;
                    end else begin
                        w_state   = ST_IDLE;
                        w_busy    = 1'b0;
                        w_done    = 1'b1;
                        w_gate_in = 4'd0;
                        w_pass    = (r_mismatch == 5'd0) && !w_miss;
                    end
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= 4'd0;
            r_cnt      <= 8'd0;
            r_gate_in  <= 4'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_tt       <= 16'h0000;
            r_mismatch <= 5'd0;
            r_first    <= 4'd0;
            r_fvalid   <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_idx      <= w_idx;
            r_cnt      <= w_cnt;
            r_gate_in  <= w_gate_in;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_pass     <= w_pass;
            r_tt       <= w_tt;
            r_mismatch <= w_mismatch;
            r_first    <= w_first;
            r_fvalid   <= w_fvalid;
        end
    end

    assign io_sweep.gate_in        = r_gate_in;
    assign io_sweep.busy           = r_busy;
    assign io_sweep.done           = r_done;
    assign io_sweep.pass           = r_pass;
    assign io_sweep.tt             = r_tt;
    assign io_sweep.mismatch_count = r_mismatch;
    assign io_sweep.first_fail     = r_first;
    assign io_sweep.fail_valid     = r_fvalid;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: golden, stuck-at and delayed gate models,
// abort, mid-sweep reset and back-to-back starts.
module tb_truth_table_sweeper;

    localparam logic [15:0] GOLD = 16'h429B;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   mode_a;
    logic [1:0] r_dly_a = 2'b00;
    logic [1:0] r_dly_b = 2'b00;
    logic [3:0] g_hist [0:255];

    always #5 clk = ~clk;

    truth_table_sweeper_if u_if_a ();
    truth_table_sweeper_if u_if_b ();

    truth_table_sweeper #(.EXPECTED(GOLD), .SETTLE(2)) u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .io_sweep (u_if_a.slave)
    );

    truth_table_sweeper #(.EXPECTED(GOLD), .SETTLE(1)) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .io_sweep (u_if_b.slave)
    );

    // Two-register delayed gate models, one per DUT.
    always_ff @(posedge clk) begin
        r_dly_a <= {r_dly_a[0], GOLD[u_if_a.gate_in]};
        r_dly_b <= {r_dly_b[0], GOLD[u_if_b.gate_in]};
    end

    always_comb begin
        case (mode_a)
            0:       u_if_a.gate_out = GOLD[u_if_a.gate_in];
            1:       u_if_a.gate_out = 1'b0;
            2:       u_if_a.gate_out = 1'b1;
            default: u_if_a.gate_out = r_dly_a[1];
        endcase
    end

    assign u_if_b.gate_out = r_dly_b[1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_in(input bit use_b, input logic s, input logic a);
        if (use_b) begin
            u_if_b.start = s;
            u_if_b.abort = a;
        end else begin
            u_if_a.start = s;
            u_if_a.abort = a;
        end
    endtask

    function automatic logic cur_done(input bit use_b);
        return use_b ? u_if_b.done : u_if_a.done;
    endfunction

    function automatic logic [3:0] cur_gate(input bit use_b);
        return use_b ? u_if_b.gate_in : u_if_a.gate_in;
    endfunction

    // Called at a negedge; start is sampled at the next edge (edge k). m counts edges after k.
    task automatic run_sweep(input bit use_b, input int start_at, input int abort_at,
                             output int m, output bit done_seen);
        m = 0;
        done_seen = 1'b0;
        drive_in(use_b, 1'b1, 1'b0);
        @(negedge clk);
        g_hist[0] = cur_gate(use_b);
        while (!done_seen && m < 200) begin
            drive_in(use_b, m == start_at, m == abort_at);
            @(negedge clk);
            m++;
            g_hist[m] = cur_gate(use_b);
            if (cur_done(use_b)) done_seen = 1'b1;
            if (abort_at >= 0 && m == abort_at + 1) break;
        end
        drive_in(use_b, 1'b0, 1'b0);
    endtask

    initial begin
        int  m;
        bit  ds;
        int  errs;
        int  n_done;

        rst = 1'b0;
        mode_a = 0;
        drive_in(1'b0, 1'b0, 1'b0);
        drive_in(1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("reset_busy", u_if_a.busy, 0);
        check("reset_done", u_if_a.done, 0);
        check("reset_pass", u_if_a.pass, 0);
        check("reset_tt", u_if_a.tt, 0);
        check("reset_gate_in", u_if_a.gate_in, 0);
        check("reset_fail_valid", u_if_a.fail_valid, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Golden gate, then a start on the done cycle with a stray start mid-run.
        run_sweep(1'b0, -1, -1, m, ds);
        check("golden_latency", m, 48);
        check("golden_done", ds, 1);
        check("golden_pass", u_if_a.pass, 1);
        check("golden_tt", u_if_a.tt, GOLD);
        check("golden_mismatch", u_if_a.mismatch_count, 0);
        check("golden_fail_valid", u_if_a.fail_valid, 0);
        check("golden_busy", u_if_a.busy, 0);
        errs = 0;
        for (int j = 0; j < 48; j++) if (g_hist[j] !== 4'(j / 3)) errs++;
        if (g_hist[48] !== 4'd0) errs++;
        check("golden_gate_in_steps", errs, 0);
        run_sweep(1'b0, 10, -1, m, ds);
        check("chained_latency", m, 48);
        check("chained_pass", u_if_a.pass, 1);
        @(negedge clk);
        check("done_one_cycle", u_if_a.done, 0);

        mode_a = 1;
        run_sweep(1'b0, -1, -1, m, ds);
        check("tied0_latency", m, 48);
        check("tied0_tt", u_if_a.tt, 16'h0000);
        check("tied0_mismatch", u_if_a.mismatch_count, 7);
        check("tied0_first_fail", u_if_a.first_fail, 0);
        check("tied0_fail_valid", u_if_a.fail_valid, 1);
        check("tied0_pass", u_if_a.pass, 0);

        mode_a = 2;
        @(negedge clk);
        run_sweep(1'b0, -1, -1, m, ds);
        check("tied1_tt", u_if_a.tt, 16'hFFFF);
        check("tied1_mismatch", u_if_a.mismatch_count, 9);
        check("tied1_first_fail", u_if_a.first_fail, 2);
        check("tied1_pass", u_if_a.pass, 0);

        mode_a = 3;
        repeat (3) @(negedge clk);
        run_sweep(1'b0, -1, -1, m, ds);
        check("delay_settle2_pass", u_if_a.pass, 1);
        check("delay_settle2_tt", u_if_a.tt, GOLD);

        // SETTLE=1 samples each vector one cycle early and sees the previous vector's output.
        run_sweep(1'b1, -1, -1, m, ds);
        check("delay_settle1_latency", m, 32);
        check("delay_settle1_pass", u_if_b.pass, 0);
        check("delay_settle1_mismatch", u_if_b.mismatch_count, 9);
        check("delay_settle1_tt", u_if_b.tt, 16'h8537);
        check("delay_settle1_first_fail", u_if_b.first_fail, 2);

        // Abort while vector 5 is presented.
        mode_a = 0;
        @(negedge clk);
        run_sweep(1'b0, 4, 16, m, ds);
        check("abort_vector", g_hist[16], 5);
        check("abort_edge", m, 17);
        check("abort_busy", u_if_a.busy, 0);
        check("abort_gate_in", u_if_a.gate_in, 0);
        check("abort_done", ds, 0);
        check("abort_partial_tt", u_if_a.tt, 16'h001B);
        check("abort_pass", u_if_a.pass, 0);
        n_done = 0;
        repeat (50) begin
            @(negedge clk);
            if (u_if_a.done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        run_sweep(1'b0, 20, -1, m, ds);
        check("restart_latency", m, 48);
        check("restart_pass", u_if_a.pass, 1);

        // Asynchronous reset while vector 9 is presented.
        mode_a = 1;
        @(negedge clk);
        drive_in(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        drive_in(1'b0, 1'b0, 1'b0);
        repeat (28) @(negedge clk);
        check("prereset_gate_in", u_if_a.gate_in, 9);
        check("prereset_busy", u_if_a.busy, 1);
        check("prereset_mismatch", u_if_a.mismatch_count, 5);
        #2 rst = 1'b1;
        #1;
        check("midreset_busy", u_if_a.busy, 0);
        check("midreset_gate_in", u_if_a.gate_in, 0);
        check("midreset_tt", u_if_a.tt, 0);
        check("midreset_mismatch", u_if_a.mismatch_count, 0);
        check("midreset_fail_valid", u_if_a.fail_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
